// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states, lane widths.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int LANES  = 4;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bus from the datapath plus the word-memory port of the access unit.
interface mem_access_unit_if #(parameter int DW = 32);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [DW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane extraction with sign/zero extension for loads, and lane merge for stores.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  size_e       size_i,
    input  logic        signed_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: BYTE_W];
        half_sel = word_i[{lane_i[1], 4'b0000} +: HALF_W];

        load_o  = word_i;
        merge_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                load_o = {{(32-BYTE_W){signed_i & byte_sel[BYTE_W-1]}}, byte_sel};
                merge_o[{lane_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
            end
            SZ_HALF: begin
                load_o = {{(32-HALF_W){signed_i & half_sel[HALF_W-1]}}, half_sel};
                merge_o[{lane_i[1], 4'b0000} +: HALF_W] = wdata_i[HALF_W-1:0];
            end
            SZ_WORD: merge_o = wdata_i;
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word memory with combinational read, sync write.
// Sub-word stores do read-modify-write; errors respond after one cycle without touching memory.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 200
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);
    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, old_q, rdata_q;
    size_e       size_q;
    logic        we_q, signed_q, err_q;

    logic        req_fire;
    logic        acc_err;
    size_e       req_size;
    logic [31:0] align_word, load_data, merge_data;

    assign req_size = size_e'(bus.req_size);
    assign req_fire = bus.req_valid && (state_q == ST_IDLE);

    always_comb begin
        acc_err = 1'b0;
        if (req_size == SZ_ILL)
            acc_err = 1'b1;
        else if (req_size == SZ_HALF && bus.req_addr[0])
            acc_err = 1'b1;
        else if (req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
            acc_err = 1'b1;
        else if ({2'b00, bus.req_addr[31:2]} >= DEPTH)
            acc_err = 1'b1;
    end

    // Loads align the live read; store merge works on the word captured in READ.
    assign align_word = (state_q == ST_WRITE) ? old_q : bus.mem_rdata;

    mem_lane_align u_align (
        .word_i   (align_word),
        .wdata_i  (wdata_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .lane_i   (addr_q[1:0]),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (acc_err)
                        state_d = ST_RESP;
                    else if (bus.req_we && req_size == SZ_WORD)
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            old_q    <= '0;
            rdata_q  <= '0;
            size_q   <= SZ_BYTE;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                size_q   <= req_size;
                we_q     <= bus.req_we;
                signed_q <= bus.req_signed;
                err_q    <= acc_err;
                rdata_q  <= '0;
            end
            if (state_q == ST_READ) begin
                if (we_q)
                    old_q <= bus.mem_rdata;
                else
                    rdata_q <= load_data;
            end
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_err   = (state_q == ST_RESP) && err_q;
    assign bus.resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    assign bus.mem_we     = (state_q == ST_WRITE);
    assign bus.mem_wdata  = (state_q == ST_WRITE) ? merge_data : '0;
    assign bus.mem_addr   = (state_q == ST_READ || state_q == ST_WRITE)
                          ? {2'b00, addr_q[31:2]} : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: word memory model around mem_access_unit, hand-computed expected values.
module tb_mem_access_unit;
    localparam int DEPTH = 200;

    logic clk;
    logic rst;
    logic preload;
    int   n_checks;
    int   n_fail;
    int   we_cnt;

    logic [31:0] mem [0:DEPTH-1];

    mem_access_unit_if bus ();

    mem_access_unit #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
            mem[100] <= 32'h8812_34F0;
            mem[101] <= 32'hAABB_CCDD;
            mem[102] <= 32'h0BAD_F00D;
        end else if (bus.mem_we && bus.mem_addr < DEPTH) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_we) we_cnt <= we_cnt + 1;
    end

    assign bus.mem_rdata = (bus.mem_addr < DEPTH) ? mem[bus.mem_addr[7:0]] : 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Issues one request, then scrambles the inputs to confirm they are latched.
    task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output int we_k,
                           output logic [31:0] rd, output logic er);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'h5A5A_5A5A;
        bus.req_signed = ~sg;
        lat  = 0;
        we_k = 0;
        rd   = 32'hDEAD_BEEF;
        er   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.mem_we && we_k == 0) we_k = k;
            if (bus.resp_valid) begin
                lat = k;
                rd  = bus.resp_rdata;
                er  = bus.resp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    int          lat, we_k, we_before, n_acc, n_resp;
    int          acc_cyc [3];
    logic [31:0] rd;
    logic        er;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp  [3];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        we_cnt   = 0;
        rst      = 1'b0;
        preload  = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (2) @(negedge clk);
        preload = 1'b0;
        check_eq("rst_ready", {31'b0, bus.req_ready}, 32'h1);
        check_eq("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        check_eq("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
        rst = 1'b1;

        run_req(1'b0, 2'b00, 1'b1, 32'd400, 32'h0, lat, we_k, rd, er);
        check_eq("lb_s_lat", 32'(lat), 32'd2);
        check_eq("lb_s_data", rd, 32'hFFFF_FFF0);
        check_eq("lb_s_err", {31'b0, er}, 32'h0);

        run_req(1'b0, 2'b01, 1'b0, 32'd402, 32'h0, lat, we_k, rd, er);
        check_eq("lhu_data", rd, 32'h0000_8812);
        run_req(1'b0, 2'b01, 1'b1, 32'd402, 32'h0, lat, we_k, rd, er);
        check_eq("lh_s_data", rd, 32'hFFFF_8812);
        run_req(1'b0, 2'b00, 1'b0, 32'd403, 32'h0, lat, we_k, rd, er);
        check_eq("lbu_lane3", rd, 32'h0000_0088);

        we_before = we_cnt;
        run_req(1'b1, 2'b00, 1'b0, 32'd405, 32'hFFFF_FF11, lat, we_k, rd, er);
        check_eq("sb_lat", 32'(lat), 32'd3);
        check_eq("sb_we_cycle", 32'(we_k), 32'd2);
        check_eq("sb_we_count", 32'(we_cnt - we_before), 32'd1);
        check_eq("sb_rdata", rd, 32'h0);
        check_eq("sb_mem", mem[101], 32'hAABB_11DD);
        run_req(1'b0, 2'b10, 1'b1, 32'd404, 32'h0, lat, we_k, rd, er);
        check_eq("lw_after_sb", rd, 32'hAABB_11DD);

        we_before = we_cnt;
        run_req(1'b1, 2'b10, 1'b0, 32'd408, 32'h1234_5678, lat, we_k, rd, er);
        check_eq("sw_lat", 32'(lat), 32'd2);
        check_eq("sw_we_cycle", 32'(we_k), 32'd1);
        check_eq("sw_mem", mem[102], 32'h1234_5678);

        run_req(1'b1, 2'b01, 1'b0, 32'd403, 32'hFFFF, lat, we_k, rd, er);
        check_eq("sh_mis_lat", 32'(lat), 32'd1);
        check_eq("sh_mis_err", {31'b0, er}, 32'h1);
        check_eq("sh_mis_no_we", 32'(we_cnt - we_before), 32'd1);
        run_req(1'b0, 2'b10, 1'b0, 32'd800, 32'h0, lat, we_k, rd, er);
        check_eq("lw_oor_lat", 32'(lat), 32'd1);
        check_eq("lw_oor_err", {31'b0, er}, 32'h1);
        check_eq("lw_oor_data", rd, 32'h0);
        run_req(1'b0, 2'b10, 1'b0, 32'd796, 32'h0, lat, we_k, rd, er);
        check_eq("lw_last_err", {31'b0, er}, 32'h0);
        run_req(1'b0, 2'b11, 1'b0, 32'd400, 32'h0, lat, we_k, rd, er);
        check_eq("ill_size_err", {31'b0, er}, 32'h1);
        run_req(1'b0, 2'b10, 1'b0, 32'd402, 32'h0, lat, we_k, rd, er);
        check_eq("lw_mis_err", {31'b0, er}, 32'h1);

        // Reset during the read phase of a byte store.
        we_before = we_cnt;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'd404;
        bus.req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_eq("rmw_read_addr", bus.mem_addr, 32'd101);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'b0, bus.resp_valid}, 32'h0);
        check_eq("mid_rst_rdata", bus.resp_rdata, 32'h0);
        check_eq("mid_rst_err", {31'b0, bus.resp_err}, 32'h0);
        check_eq("mid_rst_we", {31'b0, bus.mem_we}, 32'h0);
        check_eq("mid_rst_addr", bus.mem_addr, 32'h0);
        check_eq("mid_rst_wdata", bus.mem_wdata, 32'h0);
        check_eq("mid_rst_ready", {31'b0, bus.req_ready}, 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_eq("mid_rst_no_we", 32'(we_cnt - we_before), 32'd0);
        check_eq("mid_rst_mem", mem[101], 32'hAABB_11DD);
        run_req(1'b0, 2'b10, 1'b0, 32'd404, 32'h0, lat, we_k, rd, er);
        check_eq("post_rst_lat", 32'(lat), 32'd2);
        check_eq("post_rst_data", rd, 32'hAABB_11DD);

        // Back-to-back loads with req_valid held high.
        b2b_addr[0] = 32'd400; b2b_exp[0] = 32'h8812_34F0;
        b2b_addr[1] = 32'd404; b2b_exp[1] = 32'hAABB_11DD;
        b2b_addr[2] = 32'd408; b2b_exp[2] = 32'h1234_5678;
        n_acc  = 0;
        n_resp = 0;
        @(negedge clk);
        bus.req_we   = 1'b0;
        bus.req_size = 2'b10;
        for (int i = 0; i < 30 && n_resp < 3; i++) begin
            if (bus.resp_valid) begin
                check_eq("b2b_data", bus.resp_rdata, b2b_exp[n_resp]);
                check_eq("b2b_ready_resp", {31'b0, bus.req_ready}, 32'h0);
                n_resp++;
            end
            if (n_acc > 0 && i == acc_cyc[n_acc-1] + 1)
                check_eq("b2b_ready_read", {31'b0, bus.req_ready}, 32'h0);
            if (bus.req_ready && n_acc < 3) begin
                acc_cyc[n_acc] = i;
                bus.req_addr   = b2b_addr[n_acc];
                bus.req_valid  = 1'b1;
                n_acc++;
            end else if (bus.req_ready) begin
                bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check_eq("b2b_resp_count", 32'(n_resp), 32'd3);
        check_eq("b2b_acc_count", 32'(n_acc), 32'd3);
        if (n_acc == 3) begin
            check_eq("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check_eq("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
